// File: rtl/elastic_delay.sv
// elastic_delay
//   DELAY-stage stream pipeline with full backpressure and a one-entry input
//   skid register. Every stage is a register; empty stages accept from their
//   predecessor even while the output is stalled.
//   src_ready is a registered output with no combinational path from
//   dest_ready.
//
// Parameters
//   DELAY     pipeline stage count, 1..16
//   BITWIDTH  data field width
//
// Ports
//   clk           single clock
//   rst           synchronous, active-high reset
//   src_data      upstream data
//   src_valid     upstream valid
//   src_ready     upstream ready (registered)
//   dest_data     downstream data (registered)
//   dest_valid    downstream valid (registered)
//   dest_ready    downstream ready
//   stall_cycles  cycles with dest_valid=1 and dest_ready=0, saturating
//                 (ELASTIC_DELAY_STATS_EN only)
//   beat_count    dest handshakes, wrapping (ELASTIC_DELAY_STATS_EN only)
//
// Build option
//   ELASTIC_DELAY_STATS_EN  adds the stall_cycles / beat_count counters and
//                           ports; the stream behaviour is the same either way.

module elastic_delay #(
  parameter int unsigned DELAY    = 1,
  parameter int unsigned BITWIDTH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BITWIDTH-1:0] src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [BITWIDTH-1:0] dest_data,
  output logic                dest_valid,
  input  logic                dest_ready
`ifdef ELASTIC_DELAY_STATS_EN
  ,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         beat_count
`endif
);

  logic [DELAY-1:0]    v;
  logic [BITWIDTH-1:0] d [DELAY];
  logic                sv;
  logic [BITWIDTH-1:0] sd;

  // open_k[k]: stage k can take a new beat this cycle. Entry DELAY is the
  // downstream sink.
  logic [DELAY:0]      open_k;
  logic [DELAY-1:0]    v_next;
  logic                in_avail;
  logic                load0;
  logic                sv_next;
  logic                skid_load;
  logic [BITWIDTH-1:0] in_data;

  // A stage is open when the sink is ready or any stage at or beyond it is
  // empty, because every beat ahead of it can then move up one place. This is
  // computed directly from v, so there is no ripple chain through open_k.
  always_comb begin
    open_k         = '0;
    open_k[DELAY]  = dest_ready;
    for (int unsigned k = 0; k < DELAY; k++) begin
      open_k[k] = dest_ready | ~(&(v | DELAY'((32'd1 << k) - 32'd1)));
    end
  end

  always_comb begin
    in_avail  = sv | (src_valid & src_ready);
    in_data   = sv ? sd : src_data;
    load0     = in_avail & open_k[0];
    sv_next   = in_avail & ~open_k[0];
    skid_load = ~sv & src_valid & src_ready & ~open_k[0];
    v_next    = '0;
    v_next[0] = load0 | (v[0] & ~open_k[1]);
    for (int unsigned k = 1; k < DELAY; k++) begin
      v_next[k] = (v[k-1] & open_k[k]) | (v[k] & ~open_k[k+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v         <= '0;
      for (int unsigned k = 0; k < DELAY; k++) begin
        d[k] <= '0;
      end
      sv        <= 1'b0;
      sd        <= '0;
      src_ready <= 1'b0;
    end else begin
      v <= v_next;
      if (load0) begin
        d[0] <= in_data;
      end
      for (int unsigned k = 1; k < DELAY; k++) begin
        if (v[k-1] & open_k[k]) begin
          d[k] <= d[k-1];
        end
      end
      sv <= sv_next;
      if (skid_load) begin
        sd <= src_data;
      end
      // Ready tracks the skid register's next state so a beat is never
      // offered a full skid.
      src_ready <= ~sv_next;
    end
  end

  always_comb begin
    dest_valid = v[DELAY-1];
    dest_data  = d[DELAY-1];
  end

`ifdef ELASTIC_DELAY_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      beat_count   <= '0;
    end else begin
      if (dest_valid & ~dest_ready & (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (dest_valid & dest_ready) begin
        beat_count <= beat_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_elastic_delay.sv
// Self-checking bench for elastic_delay: a DELAY=3 / 8-bit instance for
// latency, backpressure, drain-while-full, random traffic, mid-stream reset
// and statistics; a DELAY=1 instance for sustained throughput.

module tb_elastic_delay;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_sdata, a_ddata;
  logic       a_svalid, a_sready, a_dvalid, a_dready;
  logic [7:0] b_sdata, b_ddata;
  logic       b_svalid, b_sready, b_dvalid, b_dready;
`ifdef ELASTIC_DELAY_STATS_EN
  logic [31:0] a_stall, a_beats, b_stall, b_beats;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int in_val = 0;
  int out_val = 0;

  elastic_delay #(.DELAY(3), .BITWIDTH(8)) u_d3 (
    .clk(clk), .rst(rst),
    .src_data(a_sdata), .src_valid(a_svalid), .src_ready(a_sready),
    .dest_data(a_ddata), .dest_valid(a_dvalid), .dest_ready(a_dready)
`ifdef ELASTIC_DELAY_STATS_EN
    , .stall_cycles(a_stall), .beat_count(a_beats)
`endif
  );

  elastic_delay #(.DELAY(1), .BITWIDTH(8)) u_d1 (
    .clk(clk), .rst(rst),
    .src_data(b_sdata), .src_valid(b_svalid), .src_ready(b_sready),
    .dest_data(b_ddata), .dest_valid(b_dvalid), .dest_ready(b_dready)
`ifdef ELASTIC_DELAY_STATS_EN
    , .stall_cycles(b_stall), .beat_count(b_beats)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One cycle of traffic on the DELAY=3 instance; src data is the running
  // input index, and every dest handshake is checked against the running
  // output index.
  task automatic step(input logic vin, input logic rdy);
    logic hs_in;
    a_svalid = vin;
    a_dready = rdy;
    hs_in    = vin & a_sready;
    a_sdata  = hs_in ? 8'(in_val) : 8'hEE;
    if (a_dvalid & rdy) begin
      check("stream_data", 32'(a_ddata), 32'(out_val & 255));
      out_val++;
    end
    tick;
    if (hs_in) in_val++;
  endtask

  initial begin
    int acc;
    int stale;
    int bin;
    int bout;
    int drops;
    logic r;
    logic hs;

    a_sdata = '0; a_svalid = 1'b0; a_dready = 1'b0;
    b_sdata = '0; b_svalid = 1'b0; b_dready = 1'b1;

    // Reset state
    rst = 1'b1;
    tick;
    tick;
    check("rst_src_ready", 32'(a_sready), 32'd0);
    check("rst_dest_valid", 32'(a_dvalid), 32'd0);
    check("rst_dest_data", 32'(a_ddata), 32'd0);
    rst = 1'b0;
    tick;
    check("post_rst_src_ready", 32'(a_sready), 32'd1);
    check("post_rst_src_ready_d1", 32'(b_sready), 32'd1);

    // Single beat latency: visible exactly DELAY cycles after its handshake
    a_dready = 1'b1;
    a_svalid = 1'b1;
    a_sdata  = 8'hA5;
    tick;
    a_svalid = 1'b0;
    a_sdata  = 8'h00;
    for (int i = 1; i <= 5; i++) begin
      check("lat_valid", 32'(a_dvalid), 32'(i == 3));
      if (i == 3) check("lat_data", 32'(a_ddata), 32'hA5);
      tick;
    end

    // Backpressure: capacity DELAY+1, then ordered drain without gaps
    a_dready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      a_svalid = 1'b1;
      r = a_sready;
      a_sdata = r ? 8'(acc + 1) : 8'hEE;
      tick;
      if (r) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_src_ready", 32'(a_sready), 32'd0);
    check("bp_hold_valid", 32'(a_dvalid), 32'd1);
    check("bp_hold_data", 32'(a_ddata), 32'd1);
    a_svalid = 1'b0;
    a_dready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_out_valid", 32'(a_dvalid), 32'd1);
      check("bp_out_data", 32'(a_ddata), 32'(i));
      tick;
    end
    check("bp_ready_back", 32'(a_sready), 32'd1);
    check("bp_empty", 32'(a_dvalid), 32'd0);

    // Full pipeline drained and refilled in the same cycle
    in_val = 16;
    out_val = 16;
    repeat (6) step(1'b1, 1'b0);
    check("full_src_ready", 32'(a_sready), 32'd0);
    step(1'b1, 1'b1);
    check("drain_fill_ready", 32'(a_sready), 32'd1);
    repeat (11) step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    check("full_conserve", 32'(out_val), 32'(in_val));

    // Random valid/ready traffic
    repeat (2000) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (10) step(1'b0, 1'b1);
    check("rand_conserve", 32'(out_val), 32'(in_val));

    // Mid-stream reset discards everything held
    repeat (5) step(1'b1, 1'b0);
    a_svalid = 1'b0;
    rst = 1'b1;
    tick;
    check("midrst_dest_valid", 32'(a_dvalid), 32'd0);
    check("midrst_src_ready", 32'(a_sready), 32'd0);
    rst = 1'b0;
    tick;
    check("midrst_ready_back", 32'(a_sready), 32'd1);
    check("midrst_valid", 32'(a_dvalid), 32'd0);
    a_dready = 1'b1;
    stale = 0;
    repeat (6) begin
      if (a_dvalid) stale++;
      tick;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    out_val = in_val;

`ifdef ELASTIC_DELAY_STATS_EN
    // 7 stalled cycles with dest_valid=1, then 5 handshakes in total
    check("stats_rst_stall", a_stall, 32'd0);
    check("stats_rst_beats", a_beats, 32'd0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("stats_dv", 32'(a_dvalid), 32'd1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    check("stats_stall", a_stall, 32'd7);
    check("stats_beats", a_beats, 32'd5);
`endif

    // DELAY=1 sustained throughput
    b_svalid = 1'b1;
    b_dready = 1'b1;
    bin = 0;
    bout = 0;
    drops = 0;
    for (int i = 0; i < 101; i++) begin
      b_sdata = 8'(bin);
      if (!b_sready) drops++;
      hs = b_sready;
      if (b_dvalid) begin
        check("d1_data", 32'(b_ddata), 32'(bout & 255));
        bout++;
      end
      tick;
      if (hs) bin++;
    end
    check("d1_count", 32'(bout), 32'd100);
    check("d1_ready_drops", 32'(drops), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
